// File: rtl/n_clic_hw_pkg.sv
// Shared types for the n_clic_hw interrupt controller.
//   csr_op_t : CSR instruction flavour, encoded like funct3 of csrr*.
//              Bit 2 selects the immediate form (rs1_zimm instead of rs1_data).
//              Bits [1:0] select write / set / clear.
package n_clic_hw_pkg;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_t;

endpackage

// File: rtl/n_clic_hw_if.sv
// CSR access bus between the core's CSR stage and n_clic_hw.
//   csr_enable : CSR instruction valid this cycle
//   csr_addr   : 12-bit CSR address
//   rs1_zimm   : 5-bit immediate for csrr*i
//   rs1_data   : 32-bit register operand
//   csr_op     : write / set / clear, register or immediate form
//   csr_out    : read data of the addressed CSR, zero-extended
//
// Handshake: csr_enable is the valid strobe and there is no ready; the
// controller accepts every access in the cycle it is presented. csr_out is
// combinational from csr_addr in that same cycle and shows the value before
// the write, which lands at the next clock edge.
interface n_clic_hw_if;
  import n_clic_hw_pkg::*;

  logic        csr_enable;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;
  csr_op_t     csr_op;
  logic [31:0] csr_out;

  modport master (
    output csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
    input  csr_out
  );

  modport slave (
    input  csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
    output csr_out
  );

endinterface

// File: rtl/n_clic_hw.sv
// n_clic_hw: nested vectored interrupt controller for the Hippomenes core.
// Sits beside fetch and redirects the PC on interrupt entry, tail chaining
// and return (pc_in all-ones marks a return).
//   clk, reset : core clock, asynchronous active-high reset
//   csr        : CSR access bus (slave side)
//   irq_in     : hardware interrupt lines, synchronous to clk
//   pc_in      : next PC from the core
//   pc_out     : possibly redirected PC
//   level_out  : current stack depth
//   int_taken  : an entry or tail-chain redirect happens this cycle
// Entry CSR k: bit0 pended, bit1 enabled, bit2 edge, bits[PrioWidth+2:3] prio.
module n_clic_hw
  import n_clic_hw_pkg::*;
#(
  parameter int VecSize        = 16,
  parameter int PrioLevels     = 8,
  parameter int IMemAddrWidth  = 12,
  parameter int VecCsrBase     = 'hb00,
  parameter int EntryCsrBase   = 'hb20,
  parameter int MIntThreshAddr = 'h347,
  parameter int StackDepthAddr = 'h350,
  localparam int PrioWidth     = $clog2(PrioLevels)
) (
  input  logic                     clk,
  input  logic                     reset,
  n_clic_hw_if.slave               csr,
  input  logic [VecSize-1:0]       irq_in,
  input  logic [IMemAddrWidth-1:0] pc_in,
  output logic [IMemAddrWidth-1:0] pc_out,
  output logic [PrioWidth-1:0]     level_out,
  output logic                     int_taken
);

  localparam int IdxW = (VecSize > 1) ? $clog2(VecSize) : 1;
  localparam int VecW = IMemAddrWidth - 2;
  localparam logic [IMemAddrWidth-1:0] RetMarker = '1;

  // Architectural state
  logic [VecSize-1:0]       irq_q;
  logic [VecSize-1:0]       pend_q;
  logic [VecSize-1:0]       en_q;
  logic [VecSize-1:0]       edge_q;
  logic [PrioWidth-1:0]     prio_q [VecSize];
  logic [VecW-1:0]          vec_q  [VecSize];
  logic [PrioWidth-1:0]     threshold_q;
  logic [PrioWidth-1:0]     level_q;
  // One slot more than can ever be used so the top index never leaves range.
  logic [IMemAddrWidth-1:0] stk_addr [PrioLevels];
  logic [PrioWidth-1:0]     stk_prio [PrioLevels];

  // CSR datapath
  logic                     wr_en;
  logic [31:0]              operand;
  logic [31:0]              rdata;
  logic [31:0]              wdata;
  logic                     thr_wr;
  logic [VecSize-1:0]       vec_wr;
  logic [VecSize-1:0]       ent_wr;
  logic                     unused_wdata;

  // Arbitration / events
  logic [VecSize-1:0]       pend_eff;
  logic [VecSize-1:0]       pend_next;
  logic                     is_ret;
  logic [PrioWidth-1:0]     top_idx;
  logic [IMemAddrWidth-1:0] top_addr;
  logic [PrioWidth-1:0]     top_prio;
  logic [PrioWidth-1:0]     arb_thr;
  logic                     found;
  logic [IdxW-1:0]          win_idx;
  logic [PrioWidth-1:0]     win_prio;
  logic                     take;
  logic                     do_push;
  logic                     do_pop;
  logic                     hw_thr;
  logic [PrioWidth-1:0]     thr_hw_val;
  logic                     stack_full;

  // Level sources mirror the sampled line; edge sources use the latched bit.
  assign pend_eff   = (edge_q & pend_q) | (~edge_q & irq_q);
  assign level_out  = level_q;
  assign stack_full = (level_q == PrioWidth'(PrioLevels - 1));
  assign csr.csr_out = rdata;
  assign unused_wdata = ^wdata[31:VecW];

  // ---------------------------------------------------------------- CSR read
  always_comb begin
    rdata  = '0;
    thr_wr = 1'b0;
    vec_wr = '0;
    ent_wr = '0;
    if (csr.csr_addr == 12'(MIntThreshAddr)) begin
      rdata  = 32'(threshold_q);
      thr_wr = wr_en;
    end
    if (csr.csr_addr == 12'(StackDepthAddr)) begin
      rdata = 32'(level_q);
    end
    for (int k = 0; k < VecSize; k++) begin
      if (csr.csr_addr == 12'(VecCsrBase + k)) begin
        rdata     = 32'(vec_q[k]);
        vec_wr[k] = wr_en;
      end
      if (csr.csr_addr == 12'(EntryCsrBase + k)) begin
        rdata     = 32'({prio_q[k], edge_q[k], en_q[k], pend_eff[k]});
        ent_wr[k] = wr_en;
      end
    end
  end

  // --------------------------------------------------------------- CSR write
  always_comb begin
    wr_en   = csr.csr_enable && (csr.csr_op != CSR_NONE);
    operand = (csr.csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ?
              {27'b0, csr.rs1_zimm} : csr.rs1_data;
    case (csr.csr_op)
      CSR_RW, CSR_RWI: wdata = operand;
      CSR_RS, CSR_RSI: wdata = rdata | operand;
      CSR_RC, CSR_RCI: wdata = rdata & ~operand;
      default:         wdata = rdata;
    endcase
  end

  // ------------------------------------------------------------- arbitration
  // On a return, a pending source only needs to beat the priority of the
  // context we would otherwise pop back to (tail chaining).
  always_comb begin
    is_ret   = (pc_in == RetMarker);
    top_idx  = level_q - 1'b1;
    top_addr = stk_addr[top_idx];
    top_prio = stk_prio[top_idx];
    arb_thr  = (is_ret && level_q != '0) ? top_prio : threshold_q;
    found    = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    // Strict '>' keeps the lowest index on a priority tie.
    for (int k = 0; k < VecSize; k++) begin
      if (en_q[k] && pend_eff[k] && (prio_q[k] > arb_thr) &&
          (!found || prio_q[k] > win_prio)) begin
        found    = 1'b1;
        win_idx  = IdxW'(k);
        win_prio = prio_q[k];
      end
    end
  end

  // ------------------------------------------------------------------ events
  always_comb begin
    pc_out     = pc_in;
    int_taken  = 1'b0;
    take       = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    hw_thr     = 1'b0;
    thr_hw_val = threshold_q;
    if (!is_ret) begin
      if (found) begin
        pc_out     = {vec_q[win_idx], 2'b00};
        int_taken  = 1'b1;
        take       = 1'b1;
        do_push    = 1'b1;
        hw_thr     = 1'b1;
        thr_hw_val = win_prio;
      end
    end else if (level_q != '0) begin
      if (found) begin
        // Tail chain: stay at this depth, just switch handler.
        pc_out     = {vec_q[win_idx], 2'b00};
        int_taken  = 1'b1;
        take       = 1'b1;
        hw_thr     = 1'b1;
        thr_hw_val = win_prio;
      end else begin
        pc_out     = top_addr;
        do_pop     = 1'b1;
        hw_thr     = 1'b1;
        thr_hw_val = top_prio;
      end
    end
    // A return with an empty stack falls through: pc passes, nothing changes.
  end

  // Edge pend: software value first, then entry clear, then a hardware edge,
  // so a rising edge always survives a same-cycle clear.
  always_comb begin
    pend_next = pend_q;
    for (int k = 0; k < VecSize; k++) begin
      if (ent_wr[k])                        pend_next[k] = wdata[0];
      if (take && win_idx == IdxW'(k))      pend_next[k] = 1'b0;
      if (irq_in[k] && !irq_q[k])           pend_next[k] = 1'b1;
      if (!edge_q[k])                       pend_next[k] = 1'b0;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q       <= '0;
      pend_q      <= '0;
      en_q        <= '0;
      edge_q      <= '0;
      threshold_q <= '0;
      level_q     <= '0;
      for (int k = 0; k < VecSize; k++) begin
        prio_q[k] <= '0;
        vec_q[k]  <= '0;
      end
      for (int s = 0; s < PrioLevels; s++) begin
        stk_addr[s] <= '0;
        stk_prio[s] <= '0;
      end
    end else begin
      irq_q  <= irq_in;
      pend_q <= pend_next;
      for (int k = 0; k < VecSize; k++) begin
        if (vec_wr[k]) vec_q[k] <= wdata[VecW-1:0];
        if (ent_wr[k]) begin
          en_q[k]   <= wdata[1];
          edge_q[k] <= wdata[2];
          prio_q[k] <= wdata[PrioWidth+2:3];
        end
      end
      // Hardware threshold update wins over a same-cycle CSR write.
      if (hw_thr)      threshold_q <= thr_hw_val;
      else if (thr_wr) threshold_q <= wdata[PrioWidth-1:0];
      if (do_push && !stack_full) begin
        stk_addr[level_q] <= pc_in;
        stk_prio[level_q] <= threshold_q;
        level_q           <= level_q + 1'b1;
      end
      if (do_pop) level_q <= level_q - 1'b1;
    end
  end

  // Priorities strictly increase per push, so overflow means a broken
  // threshold sequence; the push is dropped.
  assert property (@(posedge clk) disable iff (reset) !(do_push && stack_full));

endmodule

// File: doc/n_clic_hw.md
Name: n_clic_hw

Overview:
- Next-generation nested vectored interrupt controller for the Hippomenes core.
- It adds VecSize hardware interrupt lines with per-vector edge or level trigger mode, automatic pend-clear on entry, and deterministic tie-break arbitration.
- Tail chaining is gated by priority against the preempted threshold, and stacking gets a read-only depth CSR.
- It sits beside the fetch stage: it rewrites pc_out on entry and on return, and serves its CSRs to the CSR read mux.

Parameters:
VecSize, 16, number of interrupt vectors (max 32)
PrioLevels, 8, priority levels; PrioWidth = $clog2(PrioLevels)
VecCsrBase, 'hb00, address of vector CSR k = base + k (holds IMemAddrWidth-2 bit word address)
EntryCsrBase, 'hb20, address of entry CSR k = base + k
MIntThreshAddr, 'h347, threshold CSR (read/write)
StackDepthAddr, 'h350, stack depth CSR (read-only)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
csr_enable  in  1  CSR instruction valid this cycle
csr_addr  in  12  CSR address
rs1_zimm  in  5  immediate operand for csrr*i
rs1_data  in  32  register operand
csr_op  in  csr_op_t  write / set / clear, register or immediate forms
irq_in  in  VecSize  hardware interrupt lines, synchronous to clk
pc_in  in  IMemAddrWidth  next PC from core; all-ones is the return marker
pc_out  out  IMemAddrWidth  redirected PC
csr_out  out  32  CSR read data, zero-extended
level_out  out  PrioWidth  current stack depth
int_taken  out  1  high in a cycle when an entry or a tail-chain redirect occurs

Behaviour:
- Entry CSR layout:
  - bit0 pended
  - bit1 enabled
  - bit2 edge (1 = edge, 0 = level)
  - bits[PrioWidth+2:3] prio
- Reset state:
  - all entry, vector and threshold CSRs = 0
  - stack empty, level_out = 0
  - irq_q = 0, int_taken = 0
  - csr_out = 0, pc_out = pc_in
- irq_q register: samples irq_in every cycle.
- Level mode pend:
  - pended = irq_q[k]
  - software writes to pended are ignored
- Edge mode pend:
  - irq_in[k] & ~irq_q[k] sets pended at the next edge.
  - Software write, set or clear then applies.
  - A hardware set wins over a software clear or an entry-clear in the same cycle.
- CSR write semantics:
  - Same-cycle read returns the old value.
  - Writes take effect at the next edge.
  - Immediate forms use the zero-extended rs1_zimm.
- Arbitration (combinational):
  - candidate = enabled & pended & prio > threshold.
  - Winner has the highest prio; ties go to the lowest index k.
- Entry: candidate exists and pc_in != all-ones.
  - pc_out = {vec[k], 2'b00}, int_taken = 1.
  - At the next edge: push {pc_in, threshold}, threshold = prio[k], pended[k] cleared (edge mode only).
- Return: pc_in == all-ones.
  - Tail-chain when a winner has prio > stack_top.prio:
    - pc_out = winner vector, int_taken = 1
    - threshold = winner prio, no push or pop, edge pend cleared
  - Otherwise pop:
    - pc_out = stack_top.addr
    - threshold = stack_top.prio
- Return with an empty stack: pc_out = pc_in, no state change. This is a software error.
- Stack invariant: depth ≤ PrioLevels-1 holds because priorities strictly increase per push. A push when full is dropped; a simulation assertion fires.
- No event: pc_out = pc_in, int_taken = 0.
- A CSR write to the threshold in the same cycle as an entry or return: the hardware update wins.
- CSR read map:
  - threshold CSR → threshold
  - StackDepthAddr → level_out
  - vector CSR k → vec[k]
  - entry CSR k → entry[k]
  - any other address → 0
  - The mux is purely combinational with no latch.
- Reset asserted mid-handler:
  - The stack is flushed and the threshold is 0.
  - pc_out follows pc_in on the first cycle after release.

Test Plan:
1. Edge source, vec[3] = 0x40, entry[3] = enabled, edge, prio 2; pulse irq_in[3] for one cycle. → After 2 cycles pc_out = 0x100, int_taken = 1. Next cycle threshold = 2, level_out = 1, pended[3] = 0.
2. Ties: vectors 1 and 5 both pended at prio 4. → Vector 1 is taken first. After return, vector 5 is tail-chained with no pop and level_out stays 1.
3. Preemption then return: prio 2 handler is running and irq 7 (prio 6) fires. → level_out = 2, threshold = 6. Return restores threshold 2 and pc to the interrupted address. A second return restores threshold 0 with level_out = 0.
4. Level source: irq_in[0] held high with prio 1. → Re-entry occurs after return while the line is high. Deassert, then return: pop, and no further entry.
5. Edge collision: a software clear of pended and a rising edge on the same source in the same cycle. → pended = 1 afterwards.
6. Reset asserted at depth 2. → Next cycle level_out = 0, threshold = 0, csr_out reads 0 for StackDepthAddr.
